// File: rtl/hack_rom_loader.sv
// Boot loader for the Hack instruction memory: receives a framed program image over a byte
// stream, writes it into instruction memory and holds the CPU in reset until the checksum passes.
module hack_rom_loader #(
  parameter int unsigned WORDS          = 1024,
  parameter bit          BOOT_RUN       = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        load_req,
  input  logic [15:0] cpu_pc,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_we,
  output logic        cpu_reset,
  output logic        loading,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam int unsigned PtrW = $clog2(WORDS);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLenHi  = 3'd1;
  localparam logic [2:0] StLenLo  = 3'd2;
  localparam logic [2:0] StDataHi = 3'd3;
  localparam logic [2:0] StDataLo = 3'd4;
  localparam logic [2:0] StChk    = 3'd5;
  localparam logic [2:0] StRun    = 3'd6;
  localparam logic [2:0] StError  = 3'd7;

  logic [2:0]      state_q, state_d;
  logic [7:0]      hi_q, hi_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [15:0]     words_q, words_d;
  logic [15:0]     wdata_q, wdata_d;
  logic            we_q, we_d;
  logic            cpu_reset_q, cpu_reset_d;
  logic            loading_q, loading_d;
  logic            err_q, err_d;
  logic [31:0]     tmo_q, tmo_d;

  logic [15:0] len_rx;
  logic        tmo_active;
  logic        tmo_expire;
  logic        last_word;

  assign len_rx     = {hi_q, rx_data};
  assign tmo_active = (state_q >= StLenHi) && (state_q <= StChk);
  assign tmo_expire = tmo_active && !rx_valid && (tmo_q == TIMEOUT_CYCLES - 1);
  assign last_word  = (32'(ptr_q) + 32'd1) == 32'(len_q);

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    len_d   = len_q;
    chk_d   = chk_q;
    ptr_d   = ptr_q;
    words_d = words_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    err_d   = err_q;

    // The pointer advances in the write cycle so mem_addr holds the target address meanwhile.
    if (we_q) begin
      ptr_d   = ptr_q + {{(PtrW-1){1'b0}}, 1'b1};
      words_d = words_q + 16'd1;
    end

    if (load_req) begin
      state_d = StIdle;
      err_d   = 1'b0;
    end else if (rx_valid) begin
      case (state_q)
        StIdle: begin
          if (rx_data == 8'hA5) state_d = StLenHi;
        end
        StError: begin
          if (rx_data == 8'hA5) begin
            state_d = StLenHi;
            err_d   = 1'b0;
          end
        end
        StLenHi: begin
          hi_d    = rx_data;
          state_d = StLenLo;
        end
        StLenLo: begin
          len_d = len_rx;
          if (len_rx == 16'd0 || 32'(len_rx) > WORDS) begin
            state_d = StError;
          end else begin
            state_d = StDataHi;
            ptr_d   = '0;
            chk_d   = 8'd0;
            words_d = 16'd0;
          end
        end
        StDataHi: begin
          hi_d    = rx_data;
          chk_d   = chk_q ^ rx_data;
          state_d = StDataLo;
        end
        StDataLo: begin
          chk_d   = chk_q ^ rx_data;
          wdata_d = {hi_q, rx_data};
          we_d    = 1'b1;
          state_d = last_word ? StChk : StDataHi;
        end
        StChk: begin
          state_d = (rx_data == chk_q) ? StRun : StError;
        end
        default: ;
      endcase
    end else if (tmo_expire) begin
      state_d = StError;
    end

    if (state_d == StError && state_q != StError) err_d = 1'b1;

    if (!tmo_active || rx_valid || state_d != state_q) begin
      tmo_d = 32'd0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end

    loading_d   = (state_d >= StLenHi) && (state_d <= StChk);
    cpu_reset_d = (state_q != StRun);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= BOOT_RUN ? StRun : StIdle;
      hi_q        <= 8'd0;
      len_q       <= 16'd0;
      chk_q       <= 8'd0;
      ptr_q       <= '0;
      words_q     <= 16'd0;
      wdata_q     <= 16'd0;
      we_q        <= 1'b0;
      cpu_reset_q <= 1'b1;
      loading_q   <= 1'b0;
      err_q       <= 1'b0;
      tmo_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      len_q       <= len_d;
      chk_q       <= chk_d;
      ptr_q       <= ptr_d;
      words_q     <= words_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      cpu_reset_q <= cpu_reset_d;
      loading_q   <= loading_d;
      err_q       <= err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign mem_addr     = (state_q == StRun) ? cpu_pc : 16'(ptr_q);
  assign mem_wdata    = wdata_q;
  assign mem_we       = we_q;
  assign cpu_reset    = cpu_reset_q;
  assign loading      = loading_q;
  assign load_error   = err_q;
  assign words_loaded = words_q;

endmodule
